instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
Instruction Fetch Queue (IFQ). Sits directly upstream of the dispatch decoder.
- Fetches 128-bit lines (4 instructions) from the instruction cache and buffers them.
- Presents one 32-bit instruction per cycle, with its PC, to the dispatch unit.
- Redirects and flushes on a dispatch jump or branch.

Parameters:
DEPTH, 4, number of 128-bit line entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, byte address fetched after reset (16-byte aligned)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Ifetch_Rd_En  out  1  cache read request, one-cycle pulse
Ifetch_Addr  out  32  line address {fetch_pc[31:4],4'b0}, valid with Ifetch_Rd_En
Cache_Dout  in  128  returned line; word0 = [31:0] = lowest address
Cache_Rd_Valid  in  1  Cache_Dout valid; one pulse per request, latency >=1 cycle
Ifq_Inst  out  32  head instruction; 0 when empty
Ifq_Pc_Out  out  32  byte PC of Ifq_Inst
Ifq_Empty  out  1  no instruction available
Dispatch_Ren  in  1  dispatch consumes head instruction this cycle
Dispatch_Jmp  in  1  redirect and flush
Dispatch_Jmp_Addr  in  32  redirect byte target (word aligned)

Behaviour:
- Storage:
  - DEPTH x 128 line array.
  - wr_ptr and rd_ptr are log2(DEPTH)+1 bits wide, wrap naturally.
  - rd_word is 2 bits (word offset in head line).
  - full = count==DEPTH; empty = rd_ptr==wr_ptr.
- Fetch FSM, states F_IDLE, F_WAIT, F_DROP. At most one outstanding request.
  - Ifetch_Rd_En = (F_IDLE && !full && !Dispatch_Jmp), combinational. Cache samples it at the edge; state goes to F_WAIT.
  - F_WAIT + Cache_Rd_Valid: write line at wr_ptr, wr_ptr++, fetch_pc += 16, go to F_IDLE.
  - F_WAIT + Dispatch_Jmp: go to F_DROP.
  - F_DROP + Cache_Rd_Valid: discard data, go to F_IDLE.
  - F_DROP + Dispatch_Jmp: stay in F_DROP, reload pc.
  - Cache_Rd_Valid in F_IDLE is ignored; the bench flags it as a protocol error.
- Read:
  - Ifq_Inst = line[rd_ptr][32*rd_word +: 32] when !empty, else 0.
  - Dispatch_Ren && !empty:
    - rd_pc += 4.
    - rd_word == 3: rd_word <= 0, rd_ptr++. Otherwise rd_word++.
  - Dispatch_Ren while empty is ignored; no state change.
- Latency: a line written on edge N is visible (Ifq_Empty=0) after edge N. No write-to-read bypass.
- Simultaneous write and read in one cycle: both take effect. Count is unchanged when the read retires the last word.
- Full: no request issued. A response can never arrive while full, because a request is only issued when not full.
- Jump (highest priority; overrides Ren and the write of a valid response in the same cycle):
  - rd_ptr <= wr_ptr <= 0.
  - fetch_pc <= {Dispatch_Jmp_Addr[31:4],4'b0}.
  - rd_word <= Dispatch_Jmp_Addr[3:2].
  - rd_pc <= Dispatch_Jmp_Addr.
  - A partial first line is consumed from the offset; words below the offset are skipped.
- Reset values:
  - Pointers 0, rd_word 0.
  - fetch_pc = rd_pc = RESET_PC.
  - State F_IDLE.
  - Outputs: Ifetch_Rd_En 1 in the first cycle after reset release (F_IDLE, not full), Ifq_Empty 1, Ifq_Inst 0, Ifq_Pc_Out RESET_PC.
  - Reset mid-request: the FSM returns to F_IDLE. A late Cache_Rd_Valid is ignored.
- Line array contents are not reset; they are gated by empty.

Decomposition:
- Package ifq_pkg:
  - LINE_W=128, INST_W=32, WORDS_PER_LINE=4.
  - Fetch-state enum F_IDLE/F_WAIT/F_DROP.
  - Helper function for line-base address.
- Sub-module ifq_line_ram: DEPTH x 128 register file with synchronous write and asynchronous read by pointer. The FSM and pointers stay in the top.

Test Plan:
1. Reset release, cache returns 4 words 0x11,0x22,0x33,0x44 two cycles after request -> Ifetch_Addr=0x0. Ifq_Empty falls the cycle after valid. Four Ren pulses give Ifq_Inst 0x11..0x44 with Ifq_Pc_Out 0x0,0x4,0x8,0xC, then Ifq_Empty=1.
2. No Ren, cache always answers in 1 cycle -> exactly 4 requests, Ifetch_Addr 0x00,0x10,0x20,0x30. Ifetch_Rd_En then stays 0 while full. One line drained with 4 Ren -> a 5th request with Ifetch_Addr=0x40.
3. Jump to 0x1008 while idle with a non-empty queue -> Ifq_Empty=1 next cycle, Ifetch_Addr=0x1000. After the response, Ifq_Inst=word2, Ifq_Pc_Out=0x1008. The next Ren gives Pc 0x100C, then the fetch of 0x1010.
4. Jump to 0x2000 while in F_WAIT -> the stale response arriving 3 cycles later is discarded (Ifq_Empty stays 1). The next request has Ifetch_Addr=0x2000.
5. Ren asserted while empty for 5 cycles -> pointers and Ifq_Pc_Out are unchanged. Ren + Jmp in the same cycle -> jump wins, with no word consumed.
6. Reset asserted asynchronously during F_WAIT -> outputs return to reset values immediately. A late valid is ignored, and the first request after release has Ifetch_Addr=RESET_PC.

Source files
------------

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared widths, fetch-state encoding and address helpers for the instruction fetch queue
package ifq_pkg;
  localparam int LINE_W = 128;
  localparam int INST_W = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_BYTES = LINE_W / 8;
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fetch_state_t;
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:4], 4'b0};
  endfunction
endpackage

// File: rtl/ifq_line_ram.sv
// ifq_line_ram: DEPTH x 128-bit line store, synchronous write, asynchronous read
module ifq_line_ram
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetches 128-bit lines from the I-cache and hands one
// instruction per cycle with its PC to dispatch; flushes and refetches on a jump.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              Ifetch_Rd_En,
  output logic [31:0]       Ifetch_Addr,
  input  logic [LINE_W-1:0] Cache_Dout,
  input  logic              Cache_Rd_Valid,
  output logic [INST_W-1:0] Ifq_Inst,
  output logic [31:0]       Ifq_Pc_Out,
  output logic              Ifq_Empty,
  input  logic              Dispatch_Ren,
  input  logic              Dispatch_Jmp,
  input  logic [31:0]       Dispatch_Jmp_Addr
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = $clog2(WORDS_PER_LINE);
  fetch_state_t state;
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [WW-1:0] rd_word;
  logic [31:0] fetch_pc, rd_pc;
  logic [LINE_W-1:0] head_line;
  logic full, empty, wr_en;
  assign count = wr_ptr - rd_ptr;
  assign full = count == PW'(DEPTH);
  assign empty = rd_ptr == wr_ptr;
  assign wr_en = state == F_WAIT && Cache_Rd_Valid && !Dispatch_Jmp;
  assign Ifetch_Rd_En = state == F_IDLE && !full && !Dispatch_Jmp;
  assign Ifetch_Addr = line_base(fetch_pc);
  assign Ifq_Empty = empty;
  assign Ifq_Inst = empty ? '0 : head_line[INST_W*rd_word +: INST_W];
  assign Ifq_Pc_Out = rd_pc;
  ifq_line_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (Clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (Cache_Dout),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head_line)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state    <= F_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_word  <= '0;
      fetch_pc <= RESET_PC;
      rd_pc    <= RESET_PC;
    end else if (Dispatch_Jmp) begin
      // a response landing in the jump cycle closes the request, so nothing is left to drop
      state    <= (state == F_IDLE || Cache_Rd_Valid) ? F_IDLE : F_DROP;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_word  <= Dispatch_Jmp_Addr[3:2];
      fetch_pc <= line_base(Dispatch_Jmp_Addr);
      rd_pc    <= Dispatch_Jmp_Addr;
    end else begin
      if (Ifetch_Rd_En) state <= F_WAIT;
      else if (state != F_IDLE && Cache_Rd_Valid) state <= F_IDLE;
      if (wr_en) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'(LINE_BYTES);
      end
      if (Dispatch_Ren && !empty) begin
        rd_pc   <= rd_pc + 32'd4;
        rd_word <= rd_word + 1'b1;
        if (&rd_word) rd_ptr <= rd_ptr + 1'b1;
      end
    end
endmodule
